// File: rtl/lcm_stage.sv
// LCM stage fed by an upstream gcd: lcm = floor(x/g)*y.
// Restoring divide (size cycles), shift-add multiply (size cycles), then one-cycle DONE.
//   state  | meaning
//   IDLE   | waiting for en_i, operands sampled here only
//   DIV    | one quotient bit per cycle, MSB first
//   MUL    | one multiplier bit per cycle, LSB first
//   DONE   | valid_o pulse, return to IDLE
module lcm_stage #(
  parameter int size = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [size-1:0]   x_i,
  input  logic [size-1:0]   y_i,
  input  logic [size-1:0]   g_i,
  input  logic              en_i,
  output logic [2*size-1:0] lcm_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = $clog2(size + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [size-1:0]   r_g;
  logic [size-1:0]   r_rem;
  logic [size-1:0]   r_q;
  logic [2*size-1:0] r_mcand;
  logic [2*size-1:0] r_acc;
  logic [2*size-1:0] r_lcm;
  logic              r_err;

  logic [size:0]     w_trial;
  logic [size:0]     w_diff;
  logic              w_fit;
  logic [2*size-1:0] w_acc_nxt;
  logic              w_cnt_tc;
  logic              w_zero;

  // r_q holds the dividend during DIV (quotient bits shift in at the LSB), then the multiplier during MUL
  assign w_trial   = {r_rem, r_q[size-1]};
  assign w_diff    = w_trial - {1'b0, r_g};
  assign w_fit     = ~w_diff[size];
  assign w_acc_nxt = r_acc + (r_q[0] ? r_mcand : '0);
  assign w_cnt_tc  = (r_cnt == '0);
  assign w_zero    = (g_i == '0) || (x_i == '0) || (y_i == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_g     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_lcm   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en_i) begin
            if (w_zero) begin
              r_lcm   <= '0;
              r_err   <= (g_i == '0);
              r_state <= S_DONE;
            end else begin
              r_g     <= g_i;
              r_q     <= x_i;
              r_rem   <= '0;
              r_mcand <= {{size{1'b0}}, y_i};
              r_acc   <= '0;
              r_cnt   <= CW'(size - 1);
              r_err   <= 1'b0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_fit ? w_diff[size-1:0] : w_trial[size-1:0];
          r_q   <= {r_q[size-2:0], w_fit};
          if (w_cnt_tc) begin
            r_cnt   <= CW'(size - 1);
            r_state <= S_MUL;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_MUL: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_q     <= r_q >> 1;
          if (w_cnt_tc) begin
            r_lcm   <= w_acc_nxt;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lcm_o   = r_lcm;
  assign valid_o = (r_state == S_DONE);
  assign busy_o  = (r_state != S_IDLE);
  assign err_o   = r_err;

endmodule

// File: tb/tb_lcm_stage.sv
// Scoreboard bench for lcm_stage: driver pushes expected results, monitor pops on valid_o.
module tb_lcm_stage;
  localparam int SZ  = 11;
  localparam int LAT = 2 * SZ;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_i = 1'b0;
  logic [SZ-1:0] x_i = '0, y_i = '0, g_i = '0;
  logic [2*SZ-1:0] lcm_o;
  logic          valid_o, busy_o, err_o;

  lcm_stage #(.size(SZ)) dut (
    .clk(clk), .rst(rst), .x_i(x_i), .y_i(y_i), .g_i(g_i), .en_i(en_i),
    .lcm_o(lcm_o), .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint lcm;
    longint err;
    longint due;
  } exp_t;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  exp_t   sb[$];
  longint last_lcm = 0;
  bit     in_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic exp_t model(int x, int y, int g, longint cap);
    exp_t e;
    if (g == 0) begin
      e.lcm = 0; e.err = 1; e.due = cap;
    end else if (x == 0 || y == 0) begin
      e.lcm = 0; e.err = 0; e.due = cap;
    end else begin
      e.lcm = longint'(x / g) * longint'(y); e.err = 0; e.due = cap + LAT;
    end
    return e;
  endfunction

  task automatic check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!in_rst) begin
        if (valid_o) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("lcm", lcm_o, e.lcm);
            check("err", err_o, e.err);
            check("latency_cycle", cyc, e.due);
            check("busy_in_done", busy_o, 1);
            last_lcm = e.lcm;
          end
        end else begin
          check("lcm_hold", lcm_o, last_lcm);
        end
      end
    end
  end

  task automatic issue(int x, int y, int g);
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", busy_o, 0);
    x_i  = SZ'(x);
    y_i  = SZ'(y);
    g_i  = SZ'(g);
    en_i = 1'b1;
    sb.push_back(model(x, y, g, cyc + 1));
    @(negedge clk);
    en_i = 1'b0;
    x_i  = SZ'($urandom);
    y_i  = SZ'($urandom);
    g_i  = SZ'($urandom);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    in_rst = 1'b1;
    @(negedge clk);
    check("rst_lcm", lcm_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    sb.delete();
    last_lcm = 0;
    rst    = 1'b0;
    in_rst = 1'b0;
  endtask

  initial begin
    int b;
    int x, y, g, kind;
    repeat (3) @(negedge clk);
    do_reset();

    // first capture on the first edge with rst low, also measures busy length
    issue(12, 18, 6);
    b = 0;
    while (busy_o && !valid_o && b < 100) begin
      b++;
      @(negedge clk);
    end
    check("busy_cycles", b, LAT);

    issue(2047, 2046, 1);
    issue(5, 7, 0);
    issue(3, 4, 1);
    issue(0, 9, 4);
    issue(9, 0, 4);

    // en_i pulse during DIV must be ignored
    issue(12, 18, 6);
    repeat (3) @(negedge clk);
    x_i = 9; y_i = 6; g_i = 3; en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;

    // reset during MUL aborts with no valid
    issue(100, 50, 7);
    repeat (LAT / 2 + 3) @(negedge clk);
    check("busy_before_abort", busy_o, 1);
    do_reset();
    repeat (3) @(negedge clk);
    issue(21, 6, 3);
    issue(10, 3, 4);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      x = $urandom_range(1, (1 << SZ) - 1);
      y = $urandom_range(1, (1 << SZ) - 1);
      g = $urandom_range(1, (1 << SZ) - 1);
      if (kind == 0) g = 0;
      else if (kind == 1) begin
        if ($urandom_range(0, 1) == 1) x = 0; else y = 0;
      end else if (kind <= 5) g = gcd(x, y);
      issue(x, y, g);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, LAT)) @(negedge clk);
        if (busy_o) begin
          x_i = SZ'($urandom); y_i = SZ'($urandom); g_i = SZ'($urandom);
          en_i = 1'b1;
          @(negedge clk);
          en_i = 1'b0;
        end
      end
    end

    b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("drain", sb.size(), 0);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
